// File: rtl/rc_div_seq_32_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DATA_WIDTH : datapath width of the add/sub core (fixed at 32)
//   DIV_ITER   : iterations per division, one quotient bit each
//   div_st_e   : 2-bit divider FSM state encoding
package rc_div_seq_32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DIV_ITER   = 32;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_RUN  = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_st_e;

endpackage

// File: rtl/rc_div_seq_32_add_sub.sv
// 32-bit adder/subtractor (RC_ADD_SUB_32).
//   A, B : operands
//   SnA  : 1 = subtract (Y = A - B), 0 = add (Y = A + B)
//   Y    : result
//   CO   : carry out; in subtract mode CO=1 means no borrow (A >= B)
module rc_add_sub_32
  import rc_div_seq_32_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  SnA,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  CO
);

  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum;

  // Two's-complement subtract: invert B and inject SnA as carry-in.
  assign b_eff = B ^ {DATA_WIDTH{SnA}};
  assign sum   = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, SnA};
  assign Y     = sum[DATA_WIDTH-1:0];
  assign CO    = sum[DATA_WIDTH];

endmodule

// File: rtl/rc_div_seq_32.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   CLK       : rising-edge clock
//   RST       : asynchronous active-low reset
//   START     : request pulse, sampled only when idle
//   DIVIDEND  : numerator, latched on accepted START
//   DIVISOR   : denominator, latched on accepted START
//   QUOTIENT  : result quotient (held until next accepted START)
//   REMAINDER : result remainder (held until next accepted START)
//   BUSY      : high while running and in the done cycle
//   DONE      : one-cycle pulse, results valid in that cycle
//   DZ        : divide-by-zero flag of the last operation
module rc_div_seq_32
  import rc_div_seq_32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DZ
);

  div_st_e          state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             dz;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] diff;
  logic             co;
  logic             ok;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;

  // Shift the next dividend bit into the partial remainder.
  assign trial = {r[WIDTH-2:0], q[WIDTH-1]};

  rc_add_sub_32 u_add_sub (
    .A   (trial),
    .B   (d),
    .SnA (1'b1),
    .Y   (diff),
    .CO  (co)
  );

  // r[MSB] set means the 33-bit shifted remainder is >= 2^32, which always
  // exceeds D; the 32-bit difference is still exact in that case.
  assign ok    = r[WIDTH-1] | co;
  assign q_nxt = {q[WIDTH-2:0], ok};
  assign r_nxt = ok ? diff : trial;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= DIV_ST_IDLE;
      cnt   <= '0;
      q     <= '0;
      d     <= '0;
      r     <= '0;
      quo   <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        DIV_ST_IDLE: begin
          if (START) begin
            busy <= 1'b1;
            if (DIVISOR != '0) begin
              q     <= DIVIDEND;
              d     <= DIVISOR;
              r     <= '0;
              cnt   <= '0;
              dz    <= 1'b0;
              state <= DIV_ST_RUN;
            end else begin
              quo   <= '1;
              rem   <= DIVIDEND;
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DIV_ST_DONE;
            end
          end
        end
        DIV_ST_RUN: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          // Outputs are loaded only on the final iteration so intermediate
          // values never appear on QUOTIENT/REMAINDER.
          if (cnt == CNT_W'(DIV_ITER - 1)) begin
            quo   <= q_nxt;
            rem   <= r_nxt;
            done  <= 1'b1;
            state <= DIV_ST_DONE;
          end
        end
        DIV_ST_DONE: begin
          busy  <= 1'b0;
          state <= DIV_ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= DIV_ST_IDLE;
        end
      endcase
    end
  end

  assign QUOTIENT  = quo;
  assign REMAINDER = rem;
  assign BUSY      = busy;
  assign DONE      = done;
  assign DZ        = dz;

endmodule
